// File: rtl/rgb_led_pkg.sv
// Shared types for the RGB LED arbiter: active-high colour codes, LED polarity helper
// and the arbiter state encoding.
package rgb_led_pkg;

  typedef logic [2:0] rgb_t;  // {R,G,B}, 1 = lit

  localparam rgb_t OFF     = 3'b000;
  localparam rgb_t RED     = 3'b100;
  localparam rgb_t YELLOW  = 3'b110;
  localparam rgb_t GREEN   = 3'b010;
  localparam rgb_t CYAN    = 3'b011;
  localparam rgb_t BLUE    = 3'b001;
  localparam rgb_t MAGENTA = 3'b101;
  localparam rgb_t WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GUARD
  } arb_state_t;

  // The board LED is wired active-low.
  function automatic rgb_t to_led_n(input rgb_t c);
    return ~c;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above the pointer,
// wrapping back to bit 0.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] sel_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    sel_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % N_REQ);
      if (!found && req_i[idx]) begin
        sel_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Shares one active-low RGB LED between N_REQ requesters: round-robin ownership with
// minimum/maximum hold times and a blank guard gap between owners.
import rgb_led_pkg::*;

module rgb_led_arbiter #(
  parameter int N_REQ    = 3,
  parameter int MIN_HOLD = 2_000_000,
  parameter int MAX_HOLD = 12_000_000,
  parameter int GAP      = 120_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] color,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               RGB_R,
  output logic               RGB_G,
  output logic               RGB_B
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int CNT_TOP = (MAX_HOLD > GAP) ? MAX_HOLD : GAP;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  arb_state_t       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  rgb_t             latch_q;

  logic [N_REQ-1:0] pick_sel;
  logic             pick_valid;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] next_ptr;
  rgb_t             own_color;
  logic             own_req;
  logic             others_req;
  logic             release_now;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .sel_o   (pick_sel),
    .valid_o (pick_valid)
  );

  // Decode the current owner from the one-hot grant and evaluate release conditions.
  always_comb begin
    owner_idx = '0;
    own_color = OFF;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        owner_idx = PTR_W'(i);
        own_color = color[3*i +: 3];
      end
    end
    own_req     = |(req & gnt_q);
    others_req  = |(req & ~gnt_q);
    next_ptr    = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
    release_now = ((cnt_q >= MIN_LAST) && !own_req) ||
                  ((cnt_q == MAX_LAST) && others_req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      latch_q <= OFF;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge register values.
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick_sel;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (own_req) latch_q <= own_color;
          if (cnt_q != MAX_LAST) cnt_q <= cnt_q + CNT_W'(1);
          if (release_now) begin
            gnt_q   <= '0;
            ptr_q   <= next_ptr;
            cnt_q   <= '0;
            latch_q <= OFF;
            state_q <= (GAP == 0) ? IDLE : GUARD;
          end
        end
        GUARD: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt                 = gnt_q;
  assign busy                = (state_q != IDLE);
  assign {RGB_R, RGB_G, RGB_B} = to_led_n(latch_q);

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Cycle-accurate scoreboard bench: two arbiters (GAP=2 and GAP=0) with short hold times.
module tb_rgb_led_arbiter;
  import rgb_led_pkg::*;

  typedef struct {
    logic [2:0] gnt;
    logic       busy;
    logic [2:0] rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_a, req_b;
  logic [8:0] color_a, color_b;
  logic [2:0] gnt_a, gnt_b;
  logic       busy_a, busy_b;
  logic       r_a, g_a, b_a, r_b, g_b, b_b;
  logic       use_gap0;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rgb_led_arbiter #(.N_REQ(3), .MIN_HOLD(4), .MAX_HOLD(10), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_a), .color(color_a), .gnt(gnt_a),
    .busy(busy_a), .RGB_R(r_a), .RGB_G(g_a), .RGB_B(b_a)
  );

  rgb_led_arbiter #(.N_REQ(3), .MIN_HOLD(4), .MAX_HOLD(10), .GAP(0)) dut_gap0 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .color(color_b), .gnt(gnt_b),
    .busy(busy_b), .RGB_R(r_b), .RGB_G(g_b), .RGB_B(b_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue the expectation for the next edge, advance one clock, then score it.
  task automatic cyc(input string tag, input logic [2:0] g, input logic b, input logic [2:0] rgb);
    exp_t e;
    e.gnt = g; e.busy = b; e.rgb = rgb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (use_gap0) begin
      check({tag, ".gnt"},  {29'd0, gnt_b},           {29'd0, e.gnt});
      check({tag, ".busy"}, {31'd0, busy_b},          {31'd0, e.busy});
      check({tag, ".rgb"},  {29'd0, r_b, g_b, b_b},   {29'd0, e.rgb});
    end else begin
      check({tag, ".gnt"},  {29'd0, gnt_a},           {29'd0, e.gnt});
      check({tag, ".busy"}, {31'd0, busy_a},          {31'd0, e.busy});
      check({tag, ".rgb"},  {29'd0, r_a, g_a, b_a},   {29'd0, e.rgb});
    end
  endtask

  // Grant entry edge (LED still dark) followed by n-1 cycles showing the owner's colour.
  task automatic grant_cycles(input string tag, input int o, input rgb_t c, input int n);
    cyc(tag, 3'(1 << o), 1'b1, 3'b111);
    for (int i = 1; i < n; i++) cyc(tag, 3'(1 << o), 1'b1, ~c);
  endtask

  // Release edge, second guard cycle, then one IDLE cycle before arbitration.
  task automatic guard_idle(input string tag);
    cyc({tag, ".g0"}, 3'b000, 1'b1, 3'b111);
    cyc({tag, ".g1"}, 3'b000, 1'b1, 3'b111);
    cyc({tag, ".idle"}, 3'b000, 1'b0, 3'b111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    use_gap0 = 1'b0;
    req_a = '0; req_b = '0; color_a = '0; color_b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset.gnt",  {29'd0, gnt_a},         32'd0);
    check("reset.busy", {31'd0, busy_a},        32'd0);
    check("reset.rgb",  {29'd0, r_a, g_a, b_a}, 32'd7);
    @(negedge clk) rst_n = 1'b1;
    cyc("idle", 3'b000, 1'b0, 3'b111);

    // Round-robin with everyone requesting: forced release at MAX_HOLD each time.
    color_a = {BLUE, GREEN, RED};
    req_a   = 3'b111;
    for (int k = 0; k < 4; k++) begin
      grant_cycles($sformatf("rr%0d", k), k % 3, color_a[3*(k%3) +: 3], 10);
      if (k == 3) req_a = 3'b000;
      guard_idle($sformatf("rr%0d", k));
    end

    // Single requester drops early: grant held until MIN_HOLD, LED keeps last colour.
    req_a = 3'b001;
    cyc("min.c0", 3'b001, 1'b1, 3'b111);
    cyc("min.c1", 3'b001, 1'b1, ~RED);
    req_a = 3'b000;
    cyc("min.c2", 3'b001, 1'b1, ~RED);
    cyc("min.c3", 3'b001, 1'b1, ~RED);
    guard_idle("min");

    // Lone requester past MAX_HOLD keeps the LED, then a live colour change.
    req_a = 3'b010;
    grant_cycles("hold", 1, GREEN, 50);
    color_a[5:3] = BLUE;
    cyc("live.c1", 3'b010, 1'b1, ~BLUE);
    cyc("live.c2", 3'b010, 1'b1, ~BLUE);
    // Counter is saturated, so a newcomer forces release on the very next edge.
    req_a = 3'b011;
    cyc("sat.rel", 3'b000, 1'b1, 3'b111);
    req_a = 3'b000;
    cyc("sat.g1", 3'b000, 1'b1, 3'b111);
    cyc("sat.idle", 3'b000, 1'b0, 3'b111);

    // Asynchronous reset in the middle of a grant, then pointer back at requester 0.
    color_a = {BLUE, GREEN, RED};
    req_a   = 3'b010;
    grant_cycles("prerst", 1, GREEN, 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.gnt",  {29'd0, gnt_a},         32'd0);
    check("midrst.busy", {31'd0, busy_a},        32'd0);
    check("midrst.rgb",  {29'd0, r_a, g_a, b_a}, 32'd7);
    req_a = 3'b111;
    @(negedge clk) rst_n = 1'b1;
    cyc("rstptr.c0", 3'b001, 1'b1, 3'b111);
    cyc("rstptr.c1", 3'b001, 1'b1, ~RED);

    // GAP=0: release goes straight to IDLE, next owner one cycle later.
    use_gap0 = 1'b1;
    color_b  = {OFF, GREEN, RED};
    req_b    = 3'b011;
    grant_cycles("g0a", 0, RED, 10);
    cyc("g0.rel", 3'b000, 1'b0, 3'b111);
    grant_cycles("g0b", 1, GREEN, 3);
    req_b = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
